// File: rtl/score_pkg.sv
// Shared parameters, FSM state encodings and double-dabble helpers for score_piece_bridge.
package score_pkg;

  localparam int unsigned DIGITS_DEF    = 6;
  localparam int unsigned MAX_SCORE_DEF = 999999;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_t;

  typedef enum logic {
    PC_IDLE = 1'b0,
    PC_REQ  = 1'b1
  } pc_state_t;

  function automatic logic [3:0] dd_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to BCD converter: one add-3/shift step per cycle, 32 cycles.
// done is high during the final shift cycle; bcd holds the result from the next cycle on.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  start,
  input  logic [31:0]           bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [31:0]          r_bin;
  logic [4*DIGITS-1:0]  r_bcd;
  logic [4:0]           r_cnt;
  logic                 r_busy;
  logic [4*DIGITS-1:0]  w_adj;

  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_adj[4*i +: 4] = dd_adj(r_bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start && !r_busy) begin
      r_bin  <= bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[31]};
      r_bin <= {r_bin[30:0], 1'b0};
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == 5'd31);
  assign bcd  = r_bcd;

endmodule

// File: rtl/score_piece_bridge.sv
// Score accumulator with BCD display conversion and piece-generator req/ack bridge.
// Optional build macro: COMBO_BONUS_EN (doubles adds landing inside the combo window).
module score_piece_bridge
  import score_pkg::*;
#(
  parameter int unsigned DIGITS       = DIGITS_DEF,
  parameter int unsigned MAX_SCORE    = MAX_SCORE_DEF,
  parameter int unsigned TYPE_W       = 3,
  parameter int unsigned COMBO_WINDOW = 64
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic [31:0]          scoreadd,
  input  logic [31:0]          terTypeChange,
  input  logic                 game_over,
  input  logic                 piece_ack,
  input  logic [TYPE_W-1:0]    piece_type,
  output logic [31:0]          score,
  output logic [31:0]          terType,
  output logic [4*DIGITS-1:0]  bcd_digits,
  output logic                 bcd_valid,
  output logic                 piece_req
);

  if ((COMBO_WINDOW == 0) || (64'(MAX_SCORE) >= pow10(DIGITS))) begin : g_param_err
    $error("score_piece_bridge: MAX_SCORE must fit in DIGITS and COMBO_WINDOW must be nonzero");
  end

  localparam logic [32:0] MAX33 = 33'(MAX_SCORE);

  logic [31:0]          r_scoreadd_q;
  logic [31:0]          r_ter_q;
  logic [31:0]          r_score;
  logic                 r_upd;
  bcd_state_t           r_bstate, w_bnext;
  logic                 r_bpend;
  logic [4*DIGITS-1:0]  r_bcd_digits;
  logic                 r_bcd_valid;
  pc_state_t            r_pstate, w_pnext;
  logic                 r_ppend;
  logic [TYPE_W-1:0]    r_ter_type;

  logic                 w_add_evt;
  logic                 w_pc_trig;
  logic [32:0]          w_inc;
  logic [32:0]          w_sum;
  logic                 w_bstart;
  logic                 w_bload;
  logic                 w_busy;
  logic                 w_done;
  logic [4*DIGITS-1:0]  w_bcd;

  assign w_add_evt = (scoreadd != r_scoreadd_q) && (scoreadd != '0) && !game_over;
  assign w_pc_trig = (terTypeChange != r_ter_q) && (terTypeChange != '0) && !game_over;

`ifdef COMBO_BONUS_EN
  localparam int unsigned CW_BITS = $clog2(COMBO_WINDOW + 1);
  localparam logic [CW_BITS-1:0] CW = CW_BITS'(COMBO_WINDOW);
  logic [CW_BITS-1:0] r_combo_cnt;

  // Counter starts saturated so the first add after reset is never a combo.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)        r_combo_cnt <= CW;
    else if (w_add_evt)       r_combo_cnt <= '0;
    else if (r_combo_cnt < CW) r_combo_cnt <= r_combo_cnt + 1'b1;
  end

  assign w_inc = (r_combo_cnt < CW) ? {scoreadd, 1'b0} : {1'b0, scoreadd};
`else
  assign w_inc = {1'b0, scoreadd};
`endif

  assign w_sum = {1'b0, r_score} + w_inc;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_scoreadd_q <= '0;
      r_ter_q      <= '0;
      r_score      <= '0;
      r_upd        <= 1'b0;
    end else begin
      r_scoreadd_q <= scoreadd;
      r_ter_q      <= terTypeChange;
      r_upd        <= w_add_evt;
      if (w_add_evt) r_score <= (w_sum > MAX33) ? MAX33[31:0] : w_sum[31:0];
    end
  end

  bin2bcd_seq #(.DIGITS(DIGITS)) u_bcd (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .start        (w_bstart),
    .bin          (r_score),
    .busy         (w_busy),
    .done         (w_done),
    .bcd          (w_bcd)
  );

  always_comb begin
    w_bnext  = r_bstate;
    w_bstart = 1'b0;
    w_bload  = 1'b0;
    case (r_bstate)
      BCD_IDLE: if (r_upd && !w_busy) begin
        w_bstart = 1'b1;
        w_bnext  = BCD_SHIFT;
      end
      BCD_SHIFT: if (w_done) w_bnext = BCD_DONE;
      BCD_DONE: begin
        w_bload = 1'b1;
        // An update landing in the DONE cycle itself counts as pending.
        if (r_bpend || r_upd) begin
          w_bstart = 1'b1;
          w_bnext  = BCD_SHIFT;
        end else begin
          w_bnext = BCD_IDLE;
        end
      end
      default: w_bnext = BCD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_bstate     <= BCD_IDLE;
      r_bpend      <= 1'b0;
      r_bcd_digits <= '0;
      r_bcd_valid  <= 1'b1;
    end else begin
      r_bstate <= w_bnext;
      if (w_bstart)                           r_bpend <= 1'b0;
      else if (r_upd && r_bstate != BCD_IDLE) r_bpend <= 1'b1;
      if (w_bload) r_bcd_digits <= w_bcd;
      if (r_upd)        r_bcd_valid <= 1'b0;
      else if (w_bload) r_bcd_valid <= !r_bpend;
    end
  end

  always_comb begin
    w_pnext = r_pstate;
    case (r_pstate)
      PC_IDLE: if (w_pc_trig || (r_ppend && !game_over)) w_pnext = PC_REQ;
      PC_REQ:  if (piece_ack) w_pnext = PC_IDLE;
      default: w_pnext = PC_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_pstate   <= PC_IDLE;
      r_ppend    <= 1'b0;
      r_ter_type <= '0;
    end else begin
      r_pstate <= w_pnext;
      if (game_over)                                 r_ppend <= 1'b0;
      else if (r_pstate == PC_IDLE && w_pnext == PC_REQ) r_ppend <= 1'b0;
      else if (r_pstate == PC_REQ && w_pc_trig)       r_ppend <= 1'b1;
      if (r_pstate == PC_REQ && piece_ack) r_ter_type <= piece_type;
    end
  end

  assign score      = r_score;
  assign terType    = {{(32-TYPE_W){1'b0}}, r_ter_type};
  assign bcd_digits = r_bcd_digits;
  assign bcd_valid  = r_bcd_valid;
  assign piece_req  = (r_pstate == PC_REQ);

endmodule

// File: tb/tb_score_piece_bridge.sv
// Self-checking bench for score_piece_bridge: directed scenarios plus randomized adds and
// piece handshakes against an arithmetic reference model.
module tb_score_piece_bridge;

  localparam int unsigned DIGITS       = 6;
  localparam int unsigned MAX_SCORE    = 999999;
  localparam int unsigned TYPE_W       = 3;
  localparam int unsigned COMBO_WINDOW = 64;

  logic                 clock;
  logic                 ctrl_reset_n;
  logic [31:0]          scoreadd;
  logic [31:0]          terTypeChange;
  logic                 game_over;
  logic                 piece_ack;
  logic [TYPE_W-1:0]    piece_type;
  logic [31:0]          score;
  logic [31:0]          terType;
  logic [4*DIGITS-1:0]  bcd_digits;
  logic                 bcd_valid;
  logic                 piece_req;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned m_score;
  longint unsigned m_prev;
  int unsigned     m_since;
  logic [31:0]     m_ter;

  score_piece_bridge #(
    .DIGITS       (DIGITS),
    .MAX_SCORE    (MAX_SCORE),
    .TYPE_W       (TYPE_W),
    .COMBO_WINDOW (COMBO_WINDOW)
  ) dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .scoreadd      (scoreadd),
    .terTypeChange (terTypeChange),
    .game_over     (game_over),
    .piece_ack     (piece_ack),
    .piece_type    (piece_type),
    .score         (score),
    .terType       (terType),
    .bcd_digits    (bcd_digits),
    .bcd_valid     (bcd_valid),
    .piece_req     (piece_req)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference score: an add fires on a new nonzero value while not game over, saturating.
  always @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      m_score = 0;
      m_prev  = 0;
      m_since = COMBO_WINDOW;
    end else begin
      if (scoreadd != m_prev && scoreadd != 0 && !game_over) begin
        longint unsigned inc;
        inc = scoreadd;
`ifdef COMBO_BONUS_EN
        if (m_since < COMBO_WINDOW) inc = inc * 2;
`endif
        m_score = (m_score + inc > MAX_SCORE) ? MAX_SCORE : m_score + inc;
        m_since = 0;
      end else if (m_since < COMBO_WINDOW) begin
        m_since++;
      end
      m_prev = scoreadd;
    end
  end

  function automatic logic [23:0] to_bcd(input longint unsigned v);
    logic [23:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    scoreadd      = '0;
    terTypeChange = '0;
    game_over     = 1'b0;
    piece_ack     = 1'b0;
    piece_type    = '0;
    ctrl_reset_n  = 1'b0;
    m_ter         = '0;
    tick();
    tick();
    ctrl_reset_n = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_terType"}, terType, 0);
    chk({tag, "_bcd"}, bcd_digits, 0);
    chk({tag, "_valid"}, bcd_valid, 1);
    chk({tag, "_req"}, piece_req, 0);
  endtask

  task automatic wait_valid(input int bound, output int lat, output logic saw_hi_early);
    lat = 0;
    saw_hi_early = 1'b0;
    while (!bcd_valid && lat < bound) begin
      tick();
      lat++;
    end
    chk("bcd_valid_timeout", bcd_valid, 1);
  endtask

  // Clear r2, write v, then wait for the display to catch up.
  task automatic add_and_settle(input logic [31:0] v);
    int lat;
    logic drop;
    scoreadd = '0;
    tick();
    scoreadd = v;
    tick();
    chk("add_score", score, m_score);
    lat = 0;
    drop = 1'b1;
    while (lat < 60) begin
      tick();
      lat++;
      if (lat == 1) drop = bcd_valid;
      if (bcd_valid) break;
    end
    chk("valid_drop", drop, 0);
    chk("bcd_valid_timeout", bcd_valid, 1);
    chk("bcd_latency_le34", (lat <= 34), 1);
    chk("held_score_once", score, m_score);
    chk("bcd_value", bcd_digits, to_bcd(m_score));
  endtask

  task automatic piece_txn(input int delay, input logic [TYPE_W-1:0] ptype);
    int w;
    w = 0;
    while (!piece_req && w < 10) begin
      tick();
      w++;
    end
    chk("req_seen", piece_req, 1);
    for (int i = 1; i < delay; i++) begin
      tick();
      chk("req_hold", piece_req, 1);
    end
    piece_ack  = 1'b1;
    piece_type = ptype;
    tick();
    piece_ack  = 1'b0;
    m_ter      = {{(32-TYPE_W){1'b0}}, ptype};
    chk("terType", terType, m_ter);
    chk("req_drop", piece_req, 0);
  endtask

  initial begin
    int lat;
    logic dummy;
    logic seen_hi;
    logic any_req;
    longint unsigned saved;

    ctrl_reset_n = 1'b0;
    do_reset();
    chk_reset_vals("rst");

    add_and_settle(32'd40);
    add_and_settle(32'd40);
    chk("score_80", score, 80);
    chk("bcd_80", bcd_digits, 24'h000080);

    do_reset();
    add_and_settle(32'd999990);
    add_and_settle(32'd100);
    chk("sat_score", score, MAX_SCORE);
    chk("sat_bcd", bcd_digits, 24'h999999);

    // Reset asserted in the middle of a conversion.
    scoreadd = '0;
    tick();
    scoreadd = 32'd40;
    repeat (10) tick();
    ctrl_reset_n = 1'b0;
    #1;
    chk_reset_vals("midshift");
    scoreadd = '0;
    tick();
    ctrl_reset_n = 1'b1;
    tick();

    // Second add while the first conversion is in flight.
    scoreadd = 32'd5;
    tick();
    scoreadd = '0;
    tick();
    seen_hi = bcd_valid;
    tick();
    seen_hi |= bcd_valid;
    scoreadd = 32'd7;
    tick();
    seen_hi |= bcd_valid;
    lat = 0;
    while (!bcd_valid && lat < 90) begin
      tick();
      lat++;
      if (!bcd_valid && lat < 30) seen_hi |= 1'b0;
    end
    chk("pend_valid_low", seen_hi, 0);
    chk("pend_conv_twice", (lat > 34), 1);
    chk("bcd_valid_timeout", bcd_valid, 1);
    chk("pend_score", score, 12);
    chk("pend_bcd", bcd_digits, 24'h000012);

    // Randomized adds, with and without clearing r2 in between.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 400000)) : 32'($urandom_range(1, 999));
      if ($urandom_range(0, 1) == 1) begin
        scoreadd = '0;
        repeat ($urandom_range(1, 2)) tick();
      end
      scoreadd = v;
      repeat ($urandom_range(1, 4)) begin
        tick();
        chk("rand_score", score, m_score);
      end
    end
    scoreadd = '0;
    tick();
    wait_valid(80, lat, dummy);
    chk("rand_final_score", score, m_score);
    chk("rand_final_bcd", bcd_digits, to_bcd(m_score));

    // Piece handshake, with a second trigger arriving during REQ.
    terTypeChange = 32'd1;
    tick();
    chk("req_first_cycle", piece_req, 1);
    terTypeChange = 32'd2;
    piece_txn(2, 3'd5);
    chk("terType_5", terType, 5);
    tick();
    chk("req_rearm", piece_req, 1);
    piece_txn(1, 3'd2);
    chk("terType_2", terType, 2);
    tick();
    chk("no_extra_req", piece_req, 0);

    // ack while idle is ignored
    piece_ack  = 1'b1;
    piece_type = 3'd7;
    tick();
    piece_ack = 1'b0;
    chk("idle_ack_ignored", terType, m_ter);
    chk("idle_ack_noreq", piece_req, 0);

    for (int it = 0; it < 8; it++) begin
      terTypeChange = terTypeChange + 32'($urandom_range(1, 5));
      tick();
      piece_txn($urandom_range(1, 4), TYPE_W'($urandom_range(0, 7)));
      tick();
    end

    // game_over blocks adds and new requests.
    saved = m_score;
    game_over = 1'b1;
    scoreadd  = '0;
    tick();
    scoreadd      = 32'd50;
    terTypeChange = terTypeChange + 32'd1;
    any_req = 1'b0;
    repeat (6) begin
      tick();
      any_req |= piece_req;
    end
    chk("go_score_frozen", score, saved);
    chk("go_no_req", any_req, 0);

    // game_over during REQ: in-flight completes, pending dropped.
    game_over     = 1'b0;
    scoreadd      = '0;
    terTypeChange = terTypeChange + 32'd1;
    tick();
    terTypeChange = terTypeChange + 32'd1;
    tick();
    game_over = 1'b1;
    piece_txn(1, 3'd3);
    any_req = 1'b0;
    repeat (4) begin
      tick();
      any_req |= piece_req;
    end
    chk("go_pend_cleared", any_req, 0);
    game_over = 1'b0;

`ifdef COMBO_BONUS_EN
    do_reset();
    scoreadd = 32'd10;
    repeat (5) tick();
    scoreadd = '0;
    tick();
    scoreadd = 32'd10;
    tick();
    chk("combo_score", score, 30);
    chk("combo_model", score, m_score);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
